axi_lite_mem_arbiter: RTL and testbench



---
 rtl/axi_lite_mem_arbiter.sv | 132 +++++++++++++
 tb/tb_axi_lite_mem_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_mem_arbiter.sv
// axi_lite_mem_arbiter: shares one AXI-Lite slave between IFU (M0) and LSU (M1),
// one whole single-beat transaction at a time, round-robin on simultaneous requests.
module axi_lite_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   m0_araddr,
  input  logic                m0_arvalid,
  output logic                m0_arready,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic [1:0]          m0_rresp,
  output logic                m0_rvalid,
  input  logic                m0_rready,
  input  logic [ADDR_W-1:0]   m0_awaddr,
  input  logic                m0_awvalid,
  output logic                m0_awready,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  input  logic                m0_wvalid,
  output logic                m0_wready,
  output logic [1:0]          m0_bresp,
  output logic                m0_bvalid,
  input  logic                m0_bready,
  input  logic [ADDR_W-1:0]   m1_araddr,
  input  logic                m1_arvalid,
  output logic                m1_arready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic [1:0]          m1_rresp,
  output logic                m1_rvalid,
  input  logic                m1_rready,
  input  logic [ADDR_W-1:0]   m1_awaddr,
  input  logic                m1_awvalid,
  output logic                m1_awready,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic                m1_wvalid,
  output logic                m1_wready,
  output logic [1:0]          m1_bresp,
  output logic                m1_bvalid,
  input  logic                m1_bready,
  output logic [ADDR_W-1:0]   s_araddr,
  output logic                s_arvalid,
  input  logic                s_arready,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic [1:0]          s_rresp,
  input  logic                s_rvalid,
  output logic                s_rready,
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic                s_awvalid,
  input  logic                s_awready,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_wvalid,
  input  logic                s_wready,
  input  logic [1:0]          s_bresp,
  input  logic                s_bvalid,
  output logic                s_bready,
  output logic                grant_owner,
  output logic                busy
);
  typedef enum logic [1:0] {IDLE, RD, WR} state_t;
  state_t state_q, state_d;
  logic owner_q, owner_d, last_owner_q, last_owner_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic req0, req1, rd, wr;
  assign req0 = m0_arvalid | m0_awvalid | m0_wvalid;
  assign req1 = m1_arvalid | m1_awvalid | m1_wvalid;
  // Gating with rst keeps every valid/ready low while reset is held, whatever the state.
  assign rd = rst & (state_q == RD);
  assign wr = rst & (state_q == WR);
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_owner_d = last_owner_q;
    aw_done_d = aw_done_q | (s_awvalid & s_awready);
    w_done_d = w_done_q | (s_wvalid & s_wready);
    if (state_q == IDLE && (req0 | req1)) begin
      owner_d = (req0 & req1) ? ~last_owner_q : req1;
      state_d = (owner_d ? m1_arvalid : m0_arvalid) ? RD : WR;
      aw_done_d = 1'b0;
      w_done_d = 1'b0;
    end
    if ((s_rvalid & s_rready) | (s_bvalid & s_bready)) begin
      state_d = IDLE;
      last_owner_d = owner_q;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_owner_q <= 1'b1;
      aw_done_q <= 1'b0;
      w_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_owner_q <= last_owner_d;
      aw_done_q <= aw_done_d;
      w_done_q <= w_done_d;
    end
  end
  assign s_araddr = owner_q ? m1_araddr : m0_araddr;
  assign s_arvalid = rd & (owner_q ? m1_arvalid : m0_arvalid);
  assign s_rready = rd & (owner_q ? m1_rready : m0_rready);
  assign s_awaddr = owner_q ? m1_awaddr : m0_awaddr;
  assign s_awvalid = wr & ~aw_done_q & (owner_q ? m1_awvalid : m0_awvalid);
  assign s_wdata = owner_q ? m1_wdata : m0_wdata;
  assign s_wstrb = owner_q ? m1_wstrb : m0_wstrb;
  assign s_wvalid = wr & ~w_done_q & (owner_q ? m1_wvalid : m0_wvalid);
  assign s_bready = wr & (owner_q ? m1_bready : m0_bready);
  assign m0_arready = rd & ~owner_q & s_arready;
  assign m1_arready = rd & owner_q & s_arready;
  assign m0_rvalid = rd & ~owner_q & s_rvalid;
  assign m1_rvalid = rd & owner_q & s_rvalid;
  assign m0_awready = wr & ~owner_q & ~aw_done_q & s_awready;
  assign m1_awready = wr & owner_q & ~aw_done_q & s_awready;
  assign m0_wready = wr & ~owner_q & ~w_done_q & s_wready;
  assign m1_wready = wr & owner_q & ~w_done_q & s_wready;
  assign m0_bvalid = wr & ~owner_q & s_bvalid;
  assign m1_bvalid = wr & owner_q & s_bvalid;
  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;
  assign m0_rresp = s_rresp;
  assign m1_rresp = s_rresp;
  assign m0_bresp = s_bresp;
  assign m1_bresp = s_bresp;
  assign grant_owner = owner_q;
  assign busy = rd | wr;
endmodule

// File: tb/tb_axi_lite_mem_arbiter.sv
// tb_axi_lite_mem_arbiter: two master models and a slave model around the arbiter;
// expected responses are queued at issue time and popped by an independent monitor.
module tb_axi_lite_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] araddr [2];
  logic [31:0] rdata [2];
  logic [31:0] awaddr [2];
  logic [31:0] wdata [2];
  logic [3:0]  wstrb [2];
  logic [1:0]  rresp [2];
  logic [1:0]  bresp [2];
  logic [31:0] s_araddr, s_rdata, s_awaddr, s_wdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_rresp, s_bresp;
  logic s_arvalid, s_rvalid, s_rready, s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic s_arready = 1'b1;
  logic grant_owner, busy;
  int n_chk = 0;
  int n_fail = 0;
  int r_lat = 1;
  int aw_lat = 0;
  int w_lat = 0;
  int b_lat = 1;
  int aw_cnt = 0;
  int w_cnt = 0;
  int b_cnt = 0;
  logic [31:0] rd_data = 32'h0;
  logic [1:0]  rd_resp = 2'b00;
  logic [1:0]  b_resp = 2'b00;
  logic aw_pulse = 1'b0;
  logic w_pulse = 1'b0;
  logic [31:0] last_awaddr, last_wdata;
  logic [3:0]  last_wstrb;
  logic [35:0] exp_q[$];
  assign s_awready = (aw_lat == 0) | aw_pulse;
  assign s_wready = (w_lat == 0) | w_pulse;

  axi_lite_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_araddr(araddr[0]), .m0_arvalid(arvalid[0]), .m0_arready(arready[0]),
    .m0_rdata(rdata[0]), .m0_rresp(rresp[0]), .m0_rvalid(rvalid[0]), .m0_rready(rready[0]),
    .m0_awaddr(awaddr[0]), .m0_awvalid(awvalid[0]), .m0_awready(awready[0]),
    .m0_wdata(wdata[0]), .m0_wstrb(wstrb[0]), .m0_wvalid(wvalid[0]), .m0_wready(wready[0]),
    .m0_bresp(bresp[0]), .m0_bvalid(bvalid[0]), .m0_bready(bready[0]),
    .m1_araddr(araddr[1]), .m1_arvalid(arvalid[1]), .m1_arready(arready[1]),
    .m1_rdata(rdata[1]), .m1_rresp(rresp[1]), .m1_rvalid(rvalid[1]), .m1_rready(rready[1]),
    .m1_awaddr(awaddr[1]), .m1_awvalid(awvalid[1]), .m1_awready(awready[1]),
    .m1_wdata(wdata[1]), .m1_wstrb(wstrb[1]), .m1_wvalid(wvalid[1]), .m1_wready(wready[1]),
    .m1_bresp(bresp[1]), .m1_bvalid(bvalid[1]), .m1_bready(bready[1]),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .grant_owner(grant_owner), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out waiting for handshake", name);
  endtask

  task automatic push(input logic m, input logic wr, input logic [31:0] d, input logic [1:0] r);
    exp_q.push_back({m, wr, d, r});
  endtask

  task automatic m_read(input int i, input logic [31:0] a);
    int n = 0;
    logic done = 1'b0;
    logic ar_hs, r_hs;
    araddr[i] = a;
    arvalid[i] = 1'b1;
    while (rst && !done && n < 200) begin
      @(negedge clk);
      ar_hs = arvalid[i] & arready[i];
      r_hs = rvalid[i] & rready[i];
      tick();
      if (ar_hs) arvalid[i] = 1'b0;
      done = r_hs;
      n++;
    end
    if (n >= 200) fail($sformatf("m%0d_read", i));
    arvalid[i] = 1'b0;
  endtask

  task automatic m_write(input int i, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    logic done = 1'b0;
    logic aw_hs, w_hs, b_hs;
    awaddr[i] = a;
    wdata[i] = d;
    wstrb[i] = s;
    awvalid[i] = 1'b1;
    wvalid[i] = 1'b1;
    while (rst && !done && n < 200) begin
      @(negedge clk);
      aw_hs = awvalid[i] & awready[i];
      w_hs = wvalid[i] & wready[i];
      b_hs = bvalid[i] & bready[i];
      tick();
      if (aw_hs) awvalid[i] = 1'b0;
      if (w_hs) wvalid[i] = 1'b0;
      done = b_hs;
      n++;
    end
    if (n >= 200) fail($sformatf("m%0d_write", i));
    awvalid[i] = 1'b0;
    wvalid[i] = 1'b0;
  endtask

  initial begin : rd_slave
    int n;
    s_rvalid = 1'b0;
    s_rdata = 32'h0;
    s_rresp = 2'b00;
    forever begin
      @(negedge clk);
      if (rst && s_arvalid) begin
        tick();
        repeat (r_lat) tick();
        s_rvalid = 1'b1;
        s_rdata = rd_data;
        s_rresp = rd_resp;
        n = 0;
        do begin @(negedge clk); n++; end while (rst && !s_rready && n < 100);
        if (n >= 100) fail("slave_r");
        tick();
        s_rvalid = 1'b0;
      end
    end
  end

  initial begin : aw_slave
    forever begin
      @(negedge clk);
      if (rst && s_awvalid) begin
        if (!s_awready) begin
          for (int k = 0; k < aw_lat; k++) begin
            tick();
            @(negedge clk);
            chk("s_awvalid_hold", s_awvalid, 1);
          end
          tick();
          aw_pulse = 1'b1;
          @(negedge clk);
        end
        last_awaddr = s_awaddr;
        tick();
        aw_pulse = 1'b0;
        aw_cnt++;
        @(negedge clk);
        chk("s_awvalid_drop", s_awvalid, 0);
      end
    end
  end

  initial begin : w_slave
    forever begin
      @(negedge clk);
      if (rst && s_wvalid) begin
        if (!s_wready) begin
          for (int k = 0; k < w_lat; k++) begin
            tick();
            @(negedge clk);
            chk("s_wvalid_hold", s_wvalid, 1);
          end
          tick();
          w_pulse = 1'b1;
          @(negedge clk);
        end
        last_wdata = s_wdata;
        last_wstrb = s_wstrb;
        tick();
        w_pulse = 1'b0;
        w_cnt++;
        @(negedge clk);
        chk("s_wvalid_drop", s_wvalid, 0);
      end
    end
  end

  initial begin : b_slave
    int n;
    s_bvalid = 1'b0;
    s_bresp = 2'b00;
    forever begin
      @(negedge clk);
      if (rst && aw_cnt > b_cnt && w_cnt > b_cnt) begin
        tick();
        repeat (b_lat) tick();
        s_bvalid = 1'b1;
        s_bresp = b_resp;
        n = 0;
        do begin @(negedge clk); n++; end while (rst && !s_bready && n < 100);
        if (n >= 100) fail("slave_b");
        tick();
        s_bvalid = 1'b0;
        b_cnt++;
      end
    end
  end

  task automatic got(input int i, input logic wr, input logic [31:0] d, input logic [1:0] r);
    logic [35:0] e;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_resp: m%0d wr=%0d got resp with empty scoreboard", i, wr);
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("resp_m%0d", i), {i[0], wr, d, r}, e);
      chk("grant_owner", grant_owner, e[35]);
      chk("busy_at_resp", busy, 1);
    end
  endtask

  initial begin : monitor
    logic idle_next = 1'b0;
    int j;
    forever begin
      @(negedge clk);
      if (idle_next) chk("idle_gap", busy, 0);
      idle_next = 1'b0;
      if (exp_q.size() > 0) begin
        j = exp_q[0][35] ? 0 : 1;
        chk($sformatf("m%0d_nonowner_quiet", j), {arready[j], awready[j], wready[j], rvalid[j], bvalid[j]}, 0);
      end
      for (int i = 0; i < 2; i++) begin
        if (rvalid[i] && rready[i]) begin got(i, 1'b0, rdata[i], rresp[i]); idle_next = 1'b1; end
        if (bvalid[i] && bready[i]) begin got(i, 1'b1, 32'h0, bresp[i]); idle_next = 1'b1; end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    arvalid = '0; awvalid = '0; wvalid = '0;
    rready = 2'b11; bready = 2'b11;
    for (int i = 0; i < 2; i++) begin
      araddr[i] = '0; awaddr[i] = '0; wdata[i] = '0; wstrb[i] = '0;
    end
    repeat (2) tick();
    arvalid[0] = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_owner", grant_owner, 0);
    chk("rst_slave_vr", {s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready}, 0);
    chk("rst_master_vr", {arready, rvalid, awready, wready, bvalid}, 0);
    tick();
    arvalid[0] = 1'b0;
    rst = 1'b1;
    tick();
    // M0 read alone: one arbitration cycle before the slave sees arvalid
    rd_data = 32'h0000_0413;
    push(1'b0, 1'b0, 32'h0000_0413, 2'b00);
    fork
      m_read(0, 32'h8000_0000);
      begin
        @(negedge clk);
        chk("t1_arb_cycle", {busy, s_arvalid}, 2'b00);
        @(negedge clk);
        chk("t1_fwd", {busy, s_arvalid}, 2'b11);
        chk("t1_araddr", s_araddr, 32'h8000_0000);
      end
    join
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    // Simultaneous M0 read / M1 write right after reset: M0 first
    rd_data = 32'h1111_2222;
    push(1'b0, 1'b0, 32'h1111_2222, 2'b00);
    push(1'b1, 1'b1, 32'h0, 2'b00);
    fork
      m_read(0, 32'h0000_0100);
      m_write(1, 32'h0000_0200, 32'hdead_beef, 4'b0110);
    join
    chk("t2_awaddr", last_awaddr, 32'h0000_0200);
    chk("t2_wdata", last_wdata, 32'hdead_beef);
    chk("t2_wstrb", last_wstrb, 4'b0110);
    // Continuous requests: grants alternate M0, M1, M0, M1
    rd_data = 32'ha5a5_0003;
    push(1'b0, 1'b0, 32'ha5a5_0003, 2'b00);
    push(1'b1, 1'b1, 32'h0, 2'b00);
    push(1'b0, 1'b0, 32'ha5a5_0003, 2'b00);
    push(1'b1, 1'b1, 32'h0, 2'b00);
    fork
      begin m_read(0, 32'h0000_0300); m_read(0, 32'h0000_0304); end
      begin m_write(1, 32'h0000_0400, 32'h1, 4'hf); m_write(1, 32'h0000_0404, 32'h2, 4'hf); end
    join
    chk("t3_last_awaddr", last_awaddr, 32'h0000_0404);
    // M1 write: W accepted at once, AW three cycles late, SLVERR response
    aw_lat = 3;
    b_resp = 2'b10;
    push(1'b1, 1'b1, 32'h0, 2'b10);
    m_write(1, 32'h1000_0040, 32'hcafe_f00d, 4'b1001);
    chk("t4_awaddr", last_awaddr, 32'h1000_0040);
    chk("t4_wdata", last_wdata, 32'hcafe_f00d);
    chk("t4_wstrb", last_wstrb, 4'b1001);
    aw_lat = 0;
    b_resp = 2'b00;
    // M0 with ar and aw together: read first, then the write
    rd_data = 32'h0000_0517;
    push(1'b0, 1'b0, 32'h0000_0517, 2'b00);
    push(1'b0, 1'b1, 32'h0, 2'b00);
    fork
      m_read(0, 32'h0000_2000);
      m_write(0, 32'h0000_2004, 32'h0000_0077, 4'hf);
    join
    chk("t5_awaddr", last_awaddr, 32'h0000_2004);
    // Reset while R is pending at the slave
    rready[0] = 1'b0;
    rd_data = 32'h0000_dead;
    fork
      m_read(0, 32'h0000_3000);
    join_none
    n = 0;
    do begin @(negedge clk); n++; end while (!s_rvalid && n < 50);
    if (n >= 50) fail("t6_wait_rvalid");
    chk("t6_busy_before", busy, 1);
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk("t6_busy", busy, 0);
    chk("t6_m0_rvalid", rvalid[0], 0);
    chk("t6_s_rready", s_rready, 0);
    chk("t6_slave_vr", {s_arvalid, s_awvalid, s_wvalid, s_bready}, 0);
    tick();
    rst = 1'b1;
    rready[0] = 1'b1;
    tick();
    @(negedge clk);
    chk("t6_idle_after", busy, 0);
    chk("t6_owner_after", grant_owner, 0);
    tick();
    // Tie after reset goes to M0 again
    rd_data = 32'h0000_600d;
    push(1'b0, 1'b1, 32'h0, 2'b00);
    push(1'b1, 1'b0, 32'h0000_600d, 2'b00);
    fork
      m_write(0, 32'h0000_4000, 32'h0000_0001, 4'hf);
      m_read(1, 32'h0000_5000);
    join
    repeat (3) tick();
    chk("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
